window_motion_ctrl: RTL and testbench



---
 rtl/anti_pinch_pkg.sv | 33 +++
 rtl/key_debounce.sv | 46 ++++
 rtl/window_motion_ctrl.sv | 169 ++++++++++++++++
 tb/tb_window_motion_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anti_pinch_pkg.sv
// Shared encodings and default 100 MHz timing for the anti-pinch window controller.
package anti_pinch_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CLOSING  = 3'd1,
      OPENING  = 3'd2,
      STOPPING = 3'd3,
      REVERSE  = 3'd4
   } state_t;

   localparam logic DIR_CLOSE = 1'b1;
   localparam logic DIR_OPEN  = 1'b0;

   localparam int unsigned CLK_HZ          = 100_000_000;
   localparam int unsigned DEF_DEB_CYCLES  = CLK_HZ / 100;   // 10 ms
   localparam int unsigned DEF_RAMP_CYCLES = CLK_HZ / 1000;  // 1 ms per duty step
   localparam int unsigned DEF_DEAD_CYCLES = CLK_HZ / 2000;  // 500 us
   localparam int unsigned DEF_REV_CYCLES  = CLK_HZ / 2;     // 0.5 s

   // Bits needed for a down-counter that is loaded with n-1.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Key input conditioning: 2-FF synchroniser, down-counting debounce filter and
// a one-cycle pulse on every accepted rising edge of the debounced level.
module key_debounce
   import anti_pinch_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic SYSCLK,
   input  logic RST,
   input  logic key_raw,
   output logic key_press
);

   localparam int unsigned CNT_W = cnt_width(DEB_CYCLES);
   localparam logic [CNT_W-1:0] DEB_LOAD = CNT_W'(DEB_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             level_q;
   logic [CNT_W-1:0] cnt_q;
   logic             sample;

   assign sample = sync_q[1];

   always_ff @(posedge SYSCLK or posedge RST) begin
      if (RST) begin
         sync_q    <= '0;
         level_q   <= 1'b0;
         cnt_q     <= '0;
         key_press <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], key_raw};
         key_press <= 1'b0;
         // any sample that agrees with the accepted level restarts the window
         if (sample == level_q) begin
            cnt_q <= DEB_LOAD;
         end else if (cnt_q == '0) begin
            level_q   <= sample;
            key_press <= sample;
            cnt_q     <= DEB_LOAD;
         end else begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/window_motion_ctrl.sv
// Anti-pinch window motor sequencer: keys to direction/enable/ramped duty,
// with automatic reverse-open when a pinch is detected while closing.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | motor off, waiting for a key press
//   CLOSING  | driving up, duty ramping
//   OPENING  | driving down, duty ramping
//   STOPPING | dead time with bridge disabled before restart/reverse
//   REVERSE  | full-duty open after a pinch, bounded by time or LIM_BOT
module window_motion_ctrl
   import anti_pinch_pkg::*;
#(
   parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
   parameter int unsigned DUTY_W      = 8,
   parameter int unsigned RAMP_CYCLES = DEF_RAMP_CYCLES,
   parameter int unsigned DEAD_CYCLES = DEF_DEAD_CYCLES,
   parameter int unsigned REV_CYCLES  = DEF_REV_CYCLES
) (
   input  logic              SYSCLK,
   input  logic              RST,
   input  logic              KEY_UP,
   input  logic              KEY_DN,
   input  logic              PINCH,
   input  logic              LIM_TOP,
   input  logic              LIM_BOT,
   output logic [DUTY_W-1:0] DUTY,
   output logic              DIR,
   output logic              MOTOR_EN,
   output logic [2:0]        STATE,
   output logic              PINCH_EVT
);

   // One timer serves ramp steps, dead time and reverse time; only one is live per state.
   localparam int unsigned TMR_W = cnt_width(max3(RAMP_CYCLES, DEAD_CYCLES, REV_CYCLES));
   localparam logic [TMR_W-1:0]  RAMP_LOAD = TMR_W'(RAMP_CYCLES - 1);
   localparam logic [TMR_W-1:0]  DEAD_LOAD = TMR_W'(DEAD_CYCLES - 1);
   localparam logic [TMR_W-1:0]  REV_LOAD  = TMR_W'(REV_CYCLES - 1);
   localparam logic [DUTY_W-1:0] DUTY_FULL = '1;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [DUTY_W-1:0]  duty_q, duty_d;
   logic               dir_q, dir_d;
   logic               rev_q, rev_d;
   logic               up_press, dn_press;
   logic               up_evt, dn_evt;
   logic               tmr_done;
   logic               ramp;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
      .SYSCLK    (SYSCLK),
      .RST       (RST),
      .key_raw   (KEY_UP),
      .key_press (up_press)
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
      .SYSCLK    (SYSCLK),
      .RST       (RST),
      .key_raw   (KEY_DN),
      .key_press (dn_press)
   );

   // simultaneous presses are ambiguous and cancel each other
   assign up_evt   = up_press & ~dn_press;
   assign dn_evt   = dn_press & ~up_press;
   assign tmr_done = (tmr_q == '0);

   always_ff @(posedge SYSCLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         duty_q  <= '0;
         dir_q   <= DIR_OPEN;
         rev_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         duty_q  <= duty_d;
         dir_q   <= dir_d;
         rev_q   <= rev_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      duty_d    = duty_q;
      dir_d     = dir_q;
      rev_d     = rev_q;
      ramp      = 1'b0;
      PINCH_EVT = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (up_evt && !LIM_TOP) begin
               state_d = CLOSING;
               dir_d   = DIR_CLOSE;
               duty_d  = '0;
               tmr_d   = RAMP_LOAD;
            end else if (dn_evt && !LIM_BOT) begin
               state_d = OPENING;
               dir_d   = DIR_OPEN;
               duty_d  = '0;
               tmr_d   = RAMP_LOAD;
            end
         end
         CLOSING: begin
            if (PINCH) begin
               PINCH_EVT = 1'b1;
               rev_d     = 1'b1;
               state_d   = STOPPING;
               tmr_d     = DEAD_LOAD;
            end else if (up_evt || dn_evt || LIM_TOP) begin
               state_d = STOPPING;
               tmr_d   = DEAD_LOAD;
            end else begin
               ramp = 1'b1;
            end
         end
         OPENING: begin
            if (up_evt || dn_evt || LIM_BOT) begin
               state_d = STOPPING;
               tmr_d   = DEAD_LOAD;
            end else begin
               ramp = 1'b1;
            end
         end
         STOPPING: begin
            if (!tmr_done) begin
               tmr_d = tmr_q - TMR_W'(1);
            end else if (rev_q) begin
               state_d = REVERSE;
               dir_d   = DIR_OPEN;
               tmr_d   = REV_LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         REVERSE: begin
            if (LIM_BOT || tmr_done) begin
               state_d = STOPPING;
               rev_d   = 1'b0;
               tmr_d   = DEAD_LOAD;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (ramp) begin
         if (tmr_done) begin
            tmr_d = RAMP_LOAD;
            if (duty_q != DUTY_FULL) duty_d = duty_q + DUTY_W'(1);
         end else begin
            tmr_d = tmr_q - TMR_W'(1);
         end
      end
   end

   // Outputs decode straight from the state register so reset stops the bridge at once.
   assign MOTOR_EN = (state_q == CLOSING) || (state_q == OPENING) || (state_q == REVERSE);
   assign DUTY     = (state_q == REVERSE) ? DUTY_FULL :
                     ((state_q == CLOSING) || (state_q == OPENING)) ? duty_q : '0;
   assign DIR      = dir_q;
   assign STATE    = state_q;

endmodule

// File: tb/tb_window_motion_ctrl.sv
// Scenario bench for window_motion_ctrl: expected outputs are queued per cycle
// as stimulus is planned and compared by a negedge scoreboard process.
module tb_window_motion_ctrl;

   localparam int DUTY_W = 4;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_CLOSE = 3'd1;
   localparam logic [2:0] ST_OPEN = 3'd2;
   localparam logic [2:0] ST_STOP = 3'd3;
   localparam logic [2:0] ST_REV = 3'd4;

   logic SYSCLK = 1'b0;
   logic RST = 1'b0;
   logic KEY_UP = 1'b0;
   logic KEY_DN = 1'b0;
   logic PINCH = 1'b0;
   logic LIM_TOP = 1'b0;
   logic LIM_BOT = 1'b0;
   logic [DUTY_W-1:0] DUTY;
   logic DIR, MOTOR_EN, PINCH_EVT;
   logic [2:0] STATE;

   typedef struct {
      int          cyc;
      string       name;
      logic [2:0]  st;
      logic        en;
      logic        dir;
      logic [3:0]  duty;
      logic        pe;
   } exp_t;

   exp_t sb_q[$];
   int cyc_cnt = 0;
   int base = 0;
   int vectors = 0;
   int miscompares = 0;

   window_motion_ctrl #(
      .DEB_CYCLES(4), .DUTY_W(DUTY_W), .RAMP_CYCLES(2), .DEAD_CYCLES(3), .REV_CYCLES(20)
   ) dut (
      .SYSCLK(SYSCLK), .RST(RST), .KEY_UP(KEY_UP), .KEY_DN(KEY_DN), .PINCH(PINCH),
      .LIM_TOP(LIM_TOP), .LIM_BOT(LIM_BOT), .DUTY(DUTY), .DIR(DIR), .MOTOR_EN(MOTOR_EN),
      .STATE(STATE), .PINCH_EVT(PINCH_EVT)
   );

   always #5 SYSCLK = ~SYSCLK;
   always @(posedge SYSCLK) cyc_cnt++;

   always @(negedge SYSCLK) begin : scoreboard
      exp_t e;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
         e = sb_q.pop_front();
         vectors++;
         if (e.cyc != cyc_cnt) begin
            miscompares++;
            $display("FAIL %s: expectation for cycle %0d was never sampled (now %0d)",
                     e.name, e.cyc, cyc_cnt);
         end else if ({STATE, MOTOR_EN, DIR, DUTY, PINCH_EVT} !==
                      {e.st, e.en, e.dir, e.duty, e.pe}) begin
            miscompares++;
            $display("FAIL %s @%0d: got state=%0d en=%b dir=%b duty=%0d evt=%b, want state=%0d en=%b dir=%b duty=%0d evt=%b",
                     e.name, cyc_cnt, STATE, MOTOR_EN, DIR, DUTY, PINCH_EVT,
                     e.st, e.en, e.dir, e.duty, e.pe);
         end
      end
   end

   function automatic void push(input int d, input string nm, input logic [2:0] st,
                                input logic en, input logic dir, input logic [3:0] duty,
                                input logic pe);
      exp_t e;
      e.cyc = base + d; e.name = nm; e.st = st; e.en = en; e.dir = dir;
      e.duty = duty; e.pe = pe;
      sb_q.push_back(e);
   endfunction

   task automatic step_to(input int d);
      while (cyc_cnt < base + d) begin
         @(posedge SYSCLK); #1;
      end
   endtask

   task automatic settle();
      repeat (8) begin
         @(posedge SYSCLK); #1;
      end
      base = cyc_cnt;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (sb_q.size() > 0 && n < 200) begin
         @(posedge SYSCLK); #1;
         n++;
      end
      if (sb_q.size() > 0) begin
         miscompares++;
         $display("FAIL %s: %0d expectations left after timeout, want 0", nm, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      #1 RST = 1'b1;
      #1;
      vectors++;
      if ({STATE, MOTOR_EN, DIR, DUTY, PINCH_EVT} !== 9'd0) begin
         miscompares++;
         $display("FAIL reset_async: got state=%0d en=%b dir=%b duty=%0d evt=%b, want all 0",
                  STATE, MOTOR_EN, DIR, DUTY, PINCH_EVT);
      end
      repeat (2) @(posedge SYSCLK);
      #1 RST = 1'b0;
      @(posedge SYSCLK); #1;
      vectors++;
      if ({STATE, MOTOR_EN, DIR, DUTY, PINCH_EVT} !== 9'd0) begin
         miscompares++;
         $display("FAIL reset_release: got state=%0d en=%b dir=%b duty=%0d, want all 0",
                  STATE, MOTOR_EN, DIR, DUTY);
      end
   endtask

   task automatic test_close_ramp();
      settle();
      push(6, "up_latency", ST_IDLE, 1'b0, 1'b0, 4'd0, 1'b0);
      for (int k = 0; k <= 34; k++)
         push(7 + k, "close_ramp", ST_CLOSE, 1'b1, 1'b1, 4'((k / 2 > 15) ? 15 : k / 2), 1'b0);
      KEY_UP = 1'b1;
      step_to(10);
      KEY_UP = 1'b0;
      drain("close_ramp");
   endtask

   task automatic test_stop_by_key();
      settle();
      push(6, "dn_stop_pre", ST_CLOSE, 1'b1, 1'b1, 4'd15, 1'b0);
      for (int d = 7; d <= 9; d++) push(d, "dn_stop_dead", ST_STOP, 1'b0, 1'b1, 4'd0, 1'b0);
      push(10, "dn_stop_idle", ST_IDLE, 1'b0, 1'b1, 4'd0, 1'b0);
      for (int d = 20; d <= 22; d++) push(d, "pinch_in_idle", ST_IDLE, 1'b0, 1'b1, 4'd0, 1'b0);
      KEY_DN = 1'b1;
      step_to(10);
      KEY_DN = 1'b0;
      step_to(20);
      PINCH = 1'b1;
      step_to(23);
      PINCH = 1'b0;
      drain("stop_by_key");
   endtask

   task automatic test_glitch();
      settle();
      for (int d = 0; d <= 12; d++) push(d, "glitch", ST_IDLE, 1'b0, 1'b1, 4'd0, 1'b0);
      KEY_UP = 1'b1;
      step_to(2);
      KEY_UP = 1'b0;
      drain("glitch");
   endtask

   task automatic test_pinch();
      settle();
      for (int d = 7; d <= 16; d++)
         push(d, "pinch_ramp", ST_CLOSE, 1'b1, 1'b1, 4'((d - 7) / 2), 1'b0);
      push(17, "pinch_evt", ST_CLOSE, 1'b1, 1'b1, 4'd5, 1'b1);
      for (int d = 18; d <= 20; d++) push(d, "pinch_dead", ST_STOP, 1'b0, 1'b1, 4'd0, 1'b0);
      for (int d = 21; d <= 40; d++) push(d, "reverse", ST_REV, 1'b1, 1'b0, 4'd15, 1'b0);
      for (int d = 41; d <= 43; d++) push(d, "rev_dead", ST_STOP, 1'b0, 1'b0, 4'd0, 1'b0);
      push(44, "rev_idle", ST_IDLE, 1'b0, 1'b0, 4'd0, 1'b0);
      KEY_UP = 1'b1;
      step_to(10);
      KEY_UP = 1'b0;
      step_to(17);
      PINCH = 1'b1;
      step_to(23);
      PINCH = 1'b0;
      drain("pinch");
   endtask

   task automatic test_open_limit();
      settle();
      push(6, "dn_latency", ST_IDLE, 1'b0, 1'b0, 4'd0, 1'b0);
      push(7, "open", ST_OPEN, 1'b1, 1'b0, 4'd0, 1'b0);
      push(8, "open", ST_OPEN, 1'b1, 1'b0, 4'd0, 1'b0);
      push(9, "open_limit", ST_OPEN, 1'b1, 1'b0, 4'd1, 1'b0);
      for (int d = 10; d <= 12; d++) push(d, "bot_dead", ST_STOP, 1'b0, 1'b0, 4'd0, 1'b0);
      push(13, "bot_idle", ST_IDLE, 1'b0, 1'b0, 4'd0, 1'b0);
      for (int d = 20; d <= 35; d++) push(d, "dn_at_limit", ST_IDLE, 1'b0, 1'b0, 4'd0, 1'b0);
      KEY_DN = 1'b1;
      step_to(9);
      LIM_BOT = 1'b1;
      step_to(10);
      KEY_DN = 1'b0;
      step_to(20);
      KEY_DN = 1'b1;
      step_to(30);
      KEY_DN = 1'b0;
      drain("open_limit");
      LIM_BOT = 1'b0;
   endtask

   task automatic test_reset_in_reverse();
      settle();
      push(7, "rr_close", ST_CLOSE, 1'b1, 1'b1, 4'd0, 1'b0);
      push(8, "rr_pinch", ST_CLOSE, 1'b1, 1'b1, 4'd0, 1'b1);
      for (int d = 9; d <= 11; d++) push(d, "rr_dead", ST_STOP, 1'b0, 1'b1, 4'd0, 1'b0);
      for (int d = 12; d <= 14; d++) push(d, "rr_reverse", ST_REV, 1'b1, 1'b0, 4'd15, 1'b0);
      push(15, "rr_reset", ST_IDLE, 1'b0, 1'b0, 4'd0, 1'b0);
      push(16, "rr_reset", ST_IDLE, 1'b0, 1'b0, 4'd0, 1'b0);
      push(27, "rr_resume", ST_CLOSE, 1'b1, 1'b1, 4'd0, 1'b0);
      push(28, "rr_resume", ST_CLOSE, 1'b1, 1'b1, 4'd0, 1'b0);
      push(29, "rr_top", ST_CLOSE, 1'b1, 1'b1, 4'd1, 1'b0);
      for (int d = 30; d <= 32; d++) push(d, "top_dead", ST_STOP, 1'b0, 1'b1, 4'd0, 1'b0);
      push(33, "top_idle", ST_IDLE, 1'b0, 1'b1, 4'd0, 1'b0);
      KEY_UP = 1'b1;
      step_to(8);
      PINCH = 1'b1;
      step_to(9);
      PINCH = 1'b0;
      step_to(10);
      KEY_UP = 1'b0;
      step_to(15);
      RST = 1'b1;
      #1;
      vectors++;
      if ({MOTOR_EN, DUTY, STATE} !== 8'd0) begin
         miscompares++;
         $display("FAIL rr_reset_now: got en=%b duty=%0d state=%0d, want 0 0 0",
                  MOTOR_EN, DUTY, STATE);
      end
      step_to(17);
      RST = 1'b0;
      step_to(20);
      KEY_UP = 1'b1;
      step_to(29);
      LIM_TOP = 1'b1;
      step_to(30);
      KEY_UP = 1'b0;
      drain("reset_in_reverse");
   endtask

   task automatic test_back_to_back();
      settle();
      for (int d = 0; d <= 16; d++) push(d, "both_keys", ST_IDLE, 1'b0, 1'b1, 4'd0, 1'b0);
      for (int d = 20; d <= 32; d++) push(d, "up_at_top", ST_IDLE, 1'b0, 1'b1, 4'd0, 1'b0);
      push(46, "dn_after", ST_IDLE, 1'b0, 1'b1, 4'd0, 1'b0);
      push(47, "dn_after", ST_OPEN, 1'b1, 1'b0, 4'd0, 1'b0);
      LIM_TOP = 1'b0;
      KEY_UP = 1'b1;
      KEY_DN = 1'b1;
      step_to(10);
      KEY_UP = 1'b0;
      KEY_DN = 1'b0;
      step_to(20);
      LIM_TOP = 1'b1;
      KEY_UP = 1'b1;
      step_to(30);
      KEY_UP = 1'b0;
      step_to(40);
      KEY_DN = 1'b1;
      step_to(50);
      KEY_DN = 1'b0;
      drain("back_to_back");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_close_ramp();
      test_stop_by_key();
      test_glitch();
      test_pinch();
      test_open_limit();
      test_reset_in_reverse();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
